// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, the IF/MEM pipeline stages and the byte-wide RAM.
// slave = arbiter side, master = pipeline/RAM side.
interface mem_arbiter_if #(
   parameter int RAM_ADDR_W = 17
);
   logic                  if_req;
   logic [31:0]           if_addr;
   logic                  if_abort;
   logic                  if_done;
   logic [31:0]           if_inst;

   logic                  mem_req;
   logic                  mem_rw;
   logic [1:0]            mem_len;
   logic [31:0]           mem_addr;
   logic [31:0]           mem_wdata;
   logic                  mem_done;
   logic [31:0]           mem_rdata;

   logic [RAM_ADDR_W-1:0] ram_a;
   logic                  ram_wr;
   logic [7:0]            ram_dout;
   logic [7:0]            ram_din;

   modport slave (
      input  if_req, if_addr, if_abort,
      input  mem_req, mem_rw, mem_len, mem_addr, mem_wdata,
      input  ram_din,
      output if_done, if_inst,
      output mem_done, mem_rdata,
      output ram_a, ram_wr, ram_dout
   );

   modport master (
      output if_req, if_addr, if_abort,
      output mem_req, mem_rw, mem_len, mem_addr, mem_wdata,
      output ram_din,
      input  if_done, if_inst,
      input  mem_done, mem_rdata,
      input  ram_a, ram_wr, ram_dout
   );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one synchronous byte RAM between fetch (IF) and load/store (MEM).
// Optional macro IF_ABORT_EN: a taken jump cancels an in-flight fetch.
module mem_arbiter #(
   parameter int RAM_ADDR_W = 17
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IF_RD  = 2'd1,
      MEM_RD = 2'd2,
      MEM_WR = 2'd3
   } state_e;

   typedef logic [RAM_ADDR_W-1:0] addr_t;

   function automatic logic [2:0] len_to_n(input logic [1:0] len);
      case (len)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  nbytes_q, nbytes_d;
   addr_t       base_q, base_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] asm_q, asm_d;

   addr_t       ram_a_q, ram_a_d;
   logic        ram_wr_q, ram_wr_d;
   logic [7:0]  ram_dout_q, ram_dout_d;
   logic        if_done_q, if_done_d;
   logic        mem_done_q, mem_done_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;

   logic        mem_gnt;
   logic        if_gnt;
   logic        if_block;
   logic        last_addr;
   logic [1:0]  rd_idx;
   logic [1:0]  wr_idx;
   addr_t       next_a;

`ifdef IF_ABORT_EN
   assign if_block = bus.if_abort;
   logic unused_hi;
   assign unused_hi = ^{bus.if_addr[31:RAM_ADDR_W], bus.mem_addr[31:RAM_ADDR_W]};
`else
   assign if_block = 1'b0;
   logic unused_hi;
   assign unused_hi = ^{bus.if_abort, bus.if_addr[31:RAM_ADDR_W], bus.mem_addr[31:RAM_ADDR_W]};
`endif

   // A port whose done is high this cycle is masked so its still-held req is not re-granted.
   assign mem_gnt   = bus.mem_req && !mem_done_q;
   assign if_gnt    = bus.if_req && !if_done_q && !if_block && !mem_gnt;

   assign last_addr = (cnt_q >= nbytes_q - 3'd1);
   assign rd_idx    = 2'(cnt_q - 3'd1);
   assign wr_idx    = 2'(cnt_q + 3'd1);
   assign next_a    = base_q + addr_t'(cnt_q) + addr_t'(1);

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      nbytes_d    = nbytes_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      asm_d       = asm_q;
      ram_a_d     = '0;
      ram_wr_d    = 1'b0;
      ram_dout_d  = 8'h00;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      if_inst_d   = if_inst_q;
      mem_rdata_d = mem_rdata_q;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            asm_d = '0;
            if (mem_gnt) begin
               state_d    = bus.mem_rw ? MEM_WR : MEM_RD;
               nbytes_d   = len_to_n(bus.mem_len);
               base_d     = bus.mem_addr[RAM_ADDR_W-1:0];
               wdata_d    = bus.mem_wdata;
               ram_a_d    = bus.mem_addr[RAM_ADDR_W-1:0];
               ram_wr_d   = bus.mem_rw;
               ram_dout_d = bus.mem_rw ? bus.mem_wdata[7:0] : 8'h00;
            end else if (if_gnt) begin
               state_d  = IF_RD;
               nbytes_d = 3'd4;
               base_d   = bus.if_addr[RAM_ADDR_W-1:0];
               wdata_d  = '0;
               ram_a_d  = bus.if_addr[RAM_ADDR_W-1:0];
            end
         end

         IF_RD, MEM_RD: begin
            cnt_d = cnt_q + 3'd1;
            if (!last_addr) begin
               ram_a_d = next_a;
            end
            // ram_din lags its address by one cycle, so byte i lands one cycle after address i.
            if (cnt_q != 3'd0) begin
               asm_d[8*rd_idx +: 8] = bus.ram_din;
            end
            if (cnt_q == nbytes_q) begin
               state_d = IDLE;
               cnt_d   = '0;
               if (state_q == IF_RD) begin
                  if_done_d = 1'b1;
                  if_inst_d = asm_d;
               end else begin
                  mem_done_d  = 1'b1;
                  mem_rdata_d = asm_d;
               end
            end
`ifdef IF_ABORT_EN
            if (state_q == IF_RD && bus.if_abort) begin
               state_d   = IDLE;
               cnt_d     = '0;
               ram_a_d   = '0;
               asm_d     = '0;
               if_done_d = 1'b0;
               if_inst_d = if_inst_q;
            end
`endif
         end

         MEM_WR: begin
            cnt_d = cnt_q + 3'd1;
            if (!last_addr) begin
               ram_a_d    = next_a;
               ram_wr_d   = 1'b1;
               ram_dout_d = wdata_q[8*wr_idx +: 8];
            end else begin
               state_d    = IDLE;
               cnt_d      = '0;
               mem_done_d = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         nbytes_q    <= '0;
         base_q      <= '0;
         wdata_q     <= '0;
         asm_q       <= '0;
         ram_a_q     <= '0;
         ram_wr_q    <= 1'b0;
         ram_dout_q  <= 8'h00;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         if_inst_q   <= '0;
         mem_rdata_q <= '0;
      end else begin
         // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         nbytes_q    <= nbytes_d;
         base_q      <= base_d;
         wdata_q     <= wdata_d;
         asm_q       <= asm_d;
         ram_a_q     <= ram_a_d;
         ram_wr_q    <= ram_wr_d;
         ram_dout_q  <= ram_dout_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
         if_inst_q   <= if_inst_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign bus.ram_a     = ram_a_q;
   assign bus.ram_wr    = ram_wr_q;
   assign bus.ram_dout  = ram_dout_q;
   assign bus.if_done   = if_done_q;
   assign bus.if_inst   = if_inst_q;
   assign bus.mem_done  = mem_done_q;
   assign bus.mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte-RAM model, read-data scoreboard, cycle-exact latency checks.
module tb_mem_arbiter;
   localparam int AW = 17;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.RAM_ADDR_W(AW)) bus ();
   mem_arbiter #(.RAM_ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Synchronous byte RAM; preload port shares the single write process.
   logic [7:0]    ram [0:(1<<AW)-1];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_a  = '0;
   logic [7:0]    pl_d  = 8'h00;
   always @(posedge clk) begin
      if (pl_en) ram[pl_a] <= pl_d;
      else if (bus.ram_wr) ram[bus.ram_a] <= bus.ram_dout;
      bus.ram_din <= ram[bus.ram_a];
   end

   int            n_cmp = 0;
   int            n_err = 0;
   int            cyc_n = 0;
   logic [31:0]   exp_if  [$];
   logic [31:0]   exp_mem [$];
   logic [AW-1:0] a_log   [$];
   logic          wr_log  [$];
   logic [7:0]    d_log   [$];
   logic          seen_done;
   logic          seen_wr;
   logic [31:0]   word;
   int            wr_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
      pl_a = a; pl_d = d; pl_en = 1'b1;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic start_log();
      cyc_n = 0;
      a_log.delete(); wr_log.delete(); d_log.delete();
   endtask

   task automatic cyc();
      @(posedge clk); #1;
      cyc_n++;
      a_log.push_back(bus.ram_a);
      wr_log.push_back(bus.ram_wr);
      d_log.push_back(bus.ram_dout);
      if (bus.if_done || bus.mem_done)
         check("done_exclusive", 64'(bus.if_done & bus.mem_done), 64'd0);
   endtask

   task automatic wait_done(input bit want_if, input bit has_data, input int exp_lat, input string tag);
      int guard = 0;
      logic [31:0] exp_d;
      while (!(want_if ? bus.if_done : bus.mem_done) && guard < 40) begin
         cyc();
         guard++;
      end
      check({tag, "_latency"}, 64'(cyc_n), 64'(exp_lat));
      if (has_data) begin
         check({tag, "_sb_depth"}, 64'(want_if ? exp_if.size() : exp_mem.size()), 64'd1);
         if ((want_if ? exp_if.size() : exp_mem.size()) != 0) begin
            exp_d = want_if ? exp_if.pop_front() : exp_mem.pop_front();
            check({tag, "_data"}, 64'(want_if ? bus.if_inst : bus.mem_rdata), 64'(exp_d));
         end
      end
   endtask

   initial begin
      bus.if_req = 1'b0;  bus.if_addr = '0;  bus.if_abort = 1'b0;
      bus.mem_req = 1'b0; bus.mem_rw = 1'b0; bus.mem_len = 2'b00;
      bus.mem_addr = '0;  bus.mem_wdata = '0;

      preload(17'h00100, 8'h13); preload(17'h00101, 8'h00);
      preload(17'h00102, 8'h50); preload(17'h00103, 8'h00);
      preload(17'h00300, 8'h93); preload(17'h00301, 8'h02);
      preload(17'h00302, 8'h10); preload(17'h00303, 8'h00);
      preload(17'h00400, 8'h11); preload(17'h00401, 8'h22);
      preload(17'h00402, 8'h33); preload(17'h00403, 8'h44);
      preload(17'h1FFFF, 8'hA1); preload(17'h00000, 8'hB2);
      preload(17'h00001, 8'hC3); preload(17'h00002, 8'hD4);
      preload(17'h00501, 8'h99); preload(17'h00602, 8'h55);

      check("rst_ram_a",     64'(bus.ram_a),     64'd0);
      check("rst_ram_wr",    64'(bus.ram_wr),    64'd0);
      check("rst_ram_dout",  64'(bus.ram_dout),  64'd0);
      check("rst_if_done",   64'(bus.if_done),   64'd0);
      check("rst_mem_done",  64'(bus.mem_done),  64'd0);
      check("rst_if_inst",   64'(bus.if_inst),   64'd0);
      check("rst_mem_rdata", 64'(bus.mem_rdata), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Fetch from 0x100.
      start_log();
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0100;
      exp_if.push_back(32'h0050_0013);
      wait_done(1'b1, 1'b1, 6, "fetch");
      bus.if_req = 1'b0;
      for (int i = 0; i < 4; i++) check($sformatf("fetch_a%0d", i), 64'(a_log[i]), 64'(32'h100 + i));
      check("fetch_a_idle", 64'(a_log[5]), 64'd0);
      check("fetch_no_wr", 64'(wr_log[0] | wr_log[1] | wr_log[2] | wr_log[3]), 64'd0);

      // Word store, granted back-to-back in the fetch done cycle; inputs scrambled after grant.
      start_log();
      bus.mem_req = 1'b1; bus.mem_rw = 1'b1; bus.mem_len = 2'b10;
      bus.mem_addr = 32'h0000_0200; bus.mem_wdata = 32'hDEAD_BEEF;
      cyc();
      bus.mem_addr = 32'h0000_0ABC; bus.mem_wdata = 32'h1111_1111; bus.mem_len = 2'b00;
      wait_done(1'b0, 1'b0, 5, "st_word");
      bus.mem_req = 1'b0;
      word = 32'hDEAD_BEEF;
      wr_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("st_word_d%0d", i), 64'(d_log[i]), 64'(word[8*i +: 8]));
         check($sformatf("st_word_a%0d", i), 64'(a_log[i]), 64'(32'h200 + i));
         if (wr_log[i]) wr_cnt++;
      end
      check("st_word_wr_cycles", 64'(wr_cnt), 64'd4);
      check("st_word_wr_idle", 64'(bus.ram_wr), 64'd0);

      // Half load at 0x202.
      @(posedge clk); #1;
      start_log();
      bus.mem_req = 1'b1; bus.mem_rw = 1'b0; bus.mem_len = 2'b01; bus.mem_addr = 32'h0000_0202;
      exp_mem.push_back(32'h0000_DEAD);
      wait_done(1'b0, 1'b1, 4, "ld_half");
      bus.mem_req = 1'b0;
      check("ld_half_a1", 64'(a_log[1]), 64'h203);

      // Contention: MEM byte load wins, IF granted in the mem_done cycle with mem_req still held.
      @(posedge clk); #1;
      start_log();
      bus.if_req = 1'b1;  bus.if_addr = 32'h0000_0100;
      bus.mem_req = 1'b1; bus.mem_rw = 1'b0; bus.mem_len = 2'b00; bus.mem_addr = 32'h0000_0201;
      exp_mem.push_back(32'h0000_00BE);
      exp_if.push_back(32'h0050_0013);
      wait_done(1'b0, 1'b1, 3, "cont_mem");
      check("cont_mem_a0", 64'(a_log[0]), 64'h201);
      start_log();
      cyc();
      bus.mem_req = 1'b0;
      check("cont_if_a0", 64'(a_log[0]), 64'h100);
      wait_done(1'b1, 1'b1, 6, "cont_if");
      bus.if_req = 1'b0;

`ifdef IF_ABORT_EN
      // Abort a fetch in C3, then refetch from 0x300.
      @(posedge clk); #1;
      start_log();
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0100;
      cyc(); cyc(); cyc();
      bus.if_abort = 1'b1; bus.if_req = 1'b0;
      cyc();
      bus.if_abort = 1'b0;
      check("abort_ram_a", 64'(bus.ram_a), 64'd0);
      seen_done = bus.if_done; seen_wr = bus.ram_wr;
      repeat (8) begin
         cyc();
         seen_done |= bus.if_done;
         seen_wr   |= bus.ram_wr;
      end
      check("abort_no_done", 64'(seen_done), 64'd0);
      check("abort_no_wr",   64'(seen_wr),   64'd0);
      start_log();
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0300;
      exp_if.push_back(32'h0010_0293);
      wait_done(1'b1, 1'b1, 6, "refetch");
      bus.if_req = 1'b0;
      check("refetch_a0", 64'(a_log[0]), 64'h300);
`else
      // Without the abort feature, a pulse on if_abort leaves the fetch untouched.
      @(posedge clk); #1;
      start_log();
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0300;
      exp_if.push_back(32'h0010_0293);
      cyc(); cyc(); cyc();
      bus.if_abort = 1'b1;
      cyc();
      bus.if_abort = 1'b0;
      wait_done(1'b1, 1'b1, 6, "abort_ignored");
      bus.if_req = 1'b0;
      check("abort_ignored_a3", 64'(a_log[3]), 64'h303);
`endif

      // Reset asserted in C2 of a word store.
      @(posedge clk); #1;
      start_log();
      bus.mem_req = 1'b1; bus.mem_rw = 1'b1; bus.mem_len = 2'b10;
      bus.mem_addr = 32'h0000_0400; bus.mem_wdata = 32'hCAFE_F00D;
      cyc(); cyc();
      #2;
      rst = 1'b0; bus.mem_req = 1'b0;
      #1;
      check("mrst_ram_a",     64'(bus.ram_a),     64'd0);
      check("mrst_ram_wr",    64'(bus.ram_wr),    64'd0);
      check("mrst_ram_dout",  64'(bus.ram_dout),  64'd0);
      check("mrst_if_done",   64'(bus.if_done),   64'd0);
      check("mrst_mem_done",  64'(bus.mem_done),  64'd0);
      check("mrst_if_inst",   64'(bus.if_inst),   64'd0);
      check("mrst_mem_rdata", 64'(bus.mem_rdata), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      seen_done = 1'b0; seen_wr = 1'b0;
      repeat (8) begin
         cyc();
         seen_done |= bus.mem_done | bus.if_done;
         seen_wr   |= bus.ram_wr;
      end
      check("mrst_no_done", 64'(seen_done), 64'd0);
      check("mrst_no_wr",   64'(seen_wr),   64'd0);
      check("mrst_ram400",  64'(ram[17'h400]), 64'h0D);
      check("mrst_ram402",  64'(ram[17'h402]), 64'h33);
      check("mrst_ram403",  64'(ram[17'h403]), 64'h44);

      // Word load wrapping at the top of the RAM (len 11, upper address bits set).
      start_log();
      bus.mem_req = 1'b1; bus.mem_rw = 1'b0; bus.mem_len = 2'b11; bus.mem_addr = 32'hABC1_FFFF;
      exp_mem.push_back(32'hD4C3_B2A1);
      wait_done(1'b0, 1'b1, 6, "wrap");
      bus.mem_req = 1'b0;
      check("wrap_a0", 64'(a_log[0]), 64'h1FFFF);
      check("wrap_a1", 64'(a_log[1]), 64'h00000);
      check("wrap_a2", 64'(a_log[2]), 64'h00001);
      check("wrap_a3", 64'(a_log[3]), 64'h00002);

      // Byte store and half store.
      @(posedge clk); #1;
      start_log();
      bus.mem_req = 1'b1; bus.mem_rw = 1'b1; bus.mem_len = 2'b00;
      bus.mem_addr = 32'h0000_0500; bus.mem_wdata = 32'h1234_5677;
      wait_done(1'b0, 1'b0, 2, "st_byte");
      bus.mem_req = 1'b0;
      check("st_byte_d0",   64'(d_log[0]), 64'h77);
      check("st_byte_ram0", 64'(ram[17'h500]), 64'h77);
      check("st_byte_ram1", 64'(ram[17'h501]), 64'h99);

      @(posedge clk); #1;
      start_log();
      bus.mem_req = 1'b1; bus.mem_rw = 1'b1; bus.mem_len = 2'b01;
      bus.mem_addr = 32'h0000_0600; bus.mem_wdata = 32'hAAAA_1234;
      wait_done(1'b0, 1'b0, 3, "st_half");
      bus.mem_req = 1'b0;
      check("st_half_ram0", 64'(ram[17'h600]), 64'h34);
      check("st_half_ram1", 64'(ram[17'h601]), 64'h12);
      check("st_half_ram2", 64'(ram[17'h602]), 64'h55);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single byte-wide synchronous RAM port between instruction fetch (IF) and the load/store stage (MEM).
- Serialises each 1/2/4-byte access into consecutive byte cycles and assembles or splits 32-bit little-endian words.
- Returns a one-cycle done pulse to the winning requester.
- Sits between the IF/MEM stages and the RAM. The stall controller freezes the pipeline while a request is outstanding.

## Interface
Parameters:
- RAM_ADDR_W, 17, width of ram_a; byte address = low RAM_ADDR_W bits of (base + byte index), wrapping modulo 2^RAM_ADDR_W

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous and active-low
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch address
- if_abort  in  1  jump taken in EX; cancels fetch (see Configuration)
- if_done  out  1  one-cycle pulse, if_inst valid
- if_inst  out  32  fetched word
- mem_req  in  1  load/store request, held until mem_done
- mem_rw  in  1  0 = load, 1 = store
- mem_len  in  2  00 byte, 01 half, 10/11 word
- mem_addr  in  32  access base address
- mem_wdata  in  32  store data, bytes taken from LSB upward
- mem_done  out  1  one-cycle pulse
- mem_rdata  out  32  load data, zero-extended; MEM stage sign-extends
- ram_a  out  RAM_ADDR_W  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte; valid in the cycle after its address is driven

## Operation
- States:
  - IDLE
  - IF_RD
  - MEM_RD
  - MEM_WR
- Byte counter `cnt`, 3 bits.
- Length N:
  - mem_len 00 → N = 1
  - mem_len 01 → N = 2
  - mem_len 10 or 11 → N = 4
  - Every fetch has N = 4.
- Grant, evaluated in IDLE only:
  - mem_req beats if_req (the older instruction wins).
  - An access in progress is never preempted.
  - In the cycle a done is high, that port's req is masked, so a held req is not re-granted.
- Base address, rw, len and wdata are latched at grant; later changes to the request inputs are ignored.
- Reads:
  - ram_a = base+i in cycle i+1, for i = 0..N-1.
  - Byte i is captured from ram_din in cycle i+2 into bits [8i+7:8i].
  - Unused upper bytes are 0.
- Writes:
  - ram_wr = 1, ram_a = base+i, ram_dout = wdata[8i+7:8i] in cycle i+1.
- Completion:
  - done pulses in the cycle after the last capture (reads) or after the last write cycle (writes).
  - The state is IDLE during the done cycle.
- When no access is active, all RAM outputs are idle: ram_wr = 0, ram_a and ram_dout hold 0.
- All outputs are registered.

Reset (rst low, any time, including mid-access):
- State → IDLE immediately, cnt = 0, latched request discarded.
- Outputs:
  - ram_a = 0
  - ram_wr = 0
  - ram_dout = 0
  - if_done = 0, mem_done = 0
  - if_inst = 0, mem_rdata = 0
- No done is issued for the aborted access.

## Timing
Cycle C0 is the cycle in which the request is sampled at the edge ending IDLE.
- Fetch / word load: ram_a driven C1–C4; bytes captured C2–C5; done high in C6.
- Half load: done in C4. Byte load: done in C3.
- Word store: ram_wr C1–C4, done C5. Half store: done C3. Byte store: done C2.
- Back-to-back: the next grant edge can be the one ending the done cycle; a new access starts at C1 immediately after the done cycle.
- Simultaneous if_req and mem_req in IDLE: MEM is served first. IF is granted in MEM's done cycle, since if_req is not masked there.
- if_done and mem_done are never high in the same cycle.

## Configuration
Macro `IF_ABORT_EN`.

Defined:
- if_abort high while in IF_RD → IDLE at the next edge, cnt cleared, ram_a = 0. No if_done is issued; captured bytes are discarded.
- if_abort high in IDLE blocks an IF grant that cycle. A MEM grant is unaffected.

Undefined:
- if_abort is ignored. A fetch always completes with if_done; the IF stage discards the stale word.
- Latency for the next fetch grows by up to 5 cycles.

## Test plan
- Fetch: RAM[0x100..0x103] = 13,00,50,00, if_req with if_addr = 0x100 → ram_a 0x100..0x103 in C1–C4; if_done in C6 with if_inst = 0x00500013.
- Store then load:
  - Store word 0xDEADBEEF at 0x200 → ram_dout EF,BE,AD,DE, mem_done in C5.
  - Load half (mem_len 01) at 0x202 → mem_rdata = 0x0000DEAD, mem_done in C4.
- Contention: if_req and mem_req (byte load) raised together → MEM served first (mem_done C3). IF granted in the mem_done cycle; ram_a = if_addr in the next cycle, if_done 6 cycles after grant.
- Abort (`IF_ABORT_EN`): if_abort pulsed in C3 of a fetch → IDLE, no if_done, ram_wr stays 0. A new if_req at 0x300 then completes normally.
- Reset mid-store: rst low during C2 of a word store → ram_wr = 0 and all outputs 0 within the same cycle. No mem_done is issued; RAM bytes 2–3 are unchanged.
- Wrap: word load at base 0x1FFFF (RAM_ADDR_W 17) → ram_a 0x1FFFF, 0x00000, 0x00001, 0x00002.
